// File: rtl/labkit_ctl.sv
`default_nettype none
// ============================================================================
// Module   : labkit_ctl
// Brief    : Front-panel controller that debounces the program buttons, drives
//            a held program-selector code and registers the display word.
// Revision : 1.0 - initial release
// ============================================================================
module labkit_ctl #(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int DATA_W      = 32,
    parameter int SW_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BTN-1:0]  btn,
    input  logic [SW_W-1:0]   sw,
    input  logic [DATA_W-1:0] reg_data,
    output logic [N_BTN-1:0]  btn_db,
    output logic [31:0]       program_selector,
    output logic              load_pulse,
    output logic              busy,
    output logic [DATA_W-1:0] disp_data
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int H      = SW_W / 2;
    localparam int M      = DATA_W / 2;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_LOAD         = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the raw button levels
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button debouncer: level must differ for DB_CYCLES edges to toggle
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_d;
        logic            db_q;
        logic            db_d;

        always_comb begin
            cnt_d = '0;
            db_d  = db_q;
            if (sync2_q[gi] != db_q) begin
                if (cnt_q == DB_LAST) begin
                    db_d  = ~db_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign btn_db[gi] = db_q;
    end

    // ------------------------------------------------------------------------
    // Rising-edge detect on the debounced levels
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] db_prev_q;
    logic [N_BTN-1:0] press;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_prev_q <= '0;
        end else begin
            db_prev_q <= btn_db;
        end
    end

    assign press = btn_db & ~db_prev_q;

    // ------------------------------------------------------------------------
    // Selector FSM
    // ------------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [31:0]       sel_q;
    logic [31:0]       sel_d;
    logic              load_q;
    logic              load_d;
    logic              busy_q;
    logic              busy_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              press_hit;
    logic [31:0]       press_code;

    // Descending scan so the lowest pressed index is the one that sticks.
    always_comb begin
        press_hit  = 1'b0;
        press_code = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_hit  = 1'b1;
                press_code = 32'(i) + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        load_d  = 1'b0;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (press_hit) begin
                    sel_d   = press_code;
                    load_d  = 1'b1;
                    hold_d  = HOLD_INIT;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hold_q == '0) begin
                    sel_d   = '0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_db == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                hold_d  = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign program_selector = sel_q;
    assign load_pulse       = load_q;
    assign busy             = busy_q;

    // ------------------------------------------------------------------------
    // Display word: raw register value or the two switch halves packed apart
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] disp_d;
    logic [DATA_W-1:0] disp_q;

    always_comb begin
        disp_d = '0;
        if (sw[SW_W-1]) begin
            disp_d = reg_data;
        end else begin
            disp_d[H-1:0]     = sw[H-1:0];
            disp_d[M+H-2:M]   = sw[SW_W-2:H];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign disp_data = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_labkit_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_labkit_ctl
// Brief    : Directed self-checking bench for labkit_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_labkit_ctl;

    logic        clock;
    logic        reset;
    logic [3:0]  btn;
    logic [15:0] sw;
    logic [31:0] reg_data;
    logic [3:0]  btn_db;
    logic [31:0] program_selector;
    logic        load_pulse;
    logic        busy;
    logic [31:0] disp_data;

    int n_vec;
    int n_err;

    labkit_ctl #(
        .N_BTN       (4),
        .DB_CYCLES   (4),
        .HOLD_CYCLES (3),
        .DATA_W      (32),
        .SW_W        (16)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .btn              (btn),
        .sw               (sw),
        .reg_data         (reg_data),
        .btn_db           (btn_db),
        .program_selector (program_selector),
        .load_pulse       (load_pulse),
        .busy             (busy),
        .disp_data        (disp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        btn      = '0;
        sw       = '0;
        reg_data = '0;
        step();
        step();
        chk("rst_sel",  program_selector, 32'd0);
        chk("rst_load", {31'd0, load_pulse}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_db",   {28'd0, btn_db}, 32'd0);
        chk("rst_disp", disp_data, 32'd0);
        reset = 1'b0;
        step();
        step();

        // Single press held, then released
        btn = 4'b0001;
        for (int e = 0; e < 20; e++) begin
            step();
            chk("t1_sel",  program_selector, (e >= 6 && e <= 8) ? 32'd1 : 32'd0);
            chk("t1_load", {31'd0, load_pulse}, (e == 6) ? 32'd1 : 32'd0);
            chk("t1_busy", {31'd0, busy}, (e >= 6) ? 32'd1 : 32'd0);
            chk("t1_db",   {28'd0, btn_db}, (e >= 5) ? 32'd1 : 32'd0);
        end
        btn = 4'b0000;
        for (int e = 0; e < 8; e++) begin
            step();
            chk("t1r_busy", {31'd0, busy}, (e < 6) ? 32'd1 : 32'd0);
            chk("t1r_db",   {28'd0, btn_db}, (e < 5) ? 32'd1 : 32'd0);
            chk("t1r_sel",  program_selector, 32'd0);
        end

        // Three-cycle glitch on button 2
        btn = 4'b0100;
        for (int e = 0; e < 11; e++) begin
            step();
            if (e == 2) btn = 4'b0000;
            chk("t2_db",   {28'd0, btn_db}, 32'd0);
            chk("t2_sel",  program_selector, 32'd0);
            chk("t2_busy", {31'd0, busy}, 32'd0);
        end

        // Simultaneous rise on buttons 1 and 3
        btn = 4'b1010;
        for (int e = 0; e < 20; e++) begin
            step();
            chk("t3_sel",  program_selector, (e >= 6 && e <= 8) ? 32'd2 : 32'd0);
            chk("t3_load", {31'd0, load_pulse}, (e == 6) ? 32'd1 : 32'd0);
            chk("t3_db",   {28'd0, btn_db}, (e >= 5) ? 32'hA : 32'd0);
        end
        btn = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("t3r_busy", {31'd0, busy}, (e < 6) ? 32'd1 : 32'd0);
            chk("t3r_sel",  program_selector, 32'd0);
        end

        // Button 3 pressed while button 0 is still loading
        btn = 4'b0001;
        for (int e = 0; e < 20; e++) begin
            step();
            chk("t4_sel", program_selector, (e >= 6 && e <= 8) ? 32'd1 : 32'd0);
            chk("t4_db",  {28'd0, btn_db}, (e >= 12) ? 32'h9 : ((e >= 5) ? 32'h1 : 32'h0));
            if (e == 6) btn = 4'b1001;
        end
        btn = 4'b0000;
        for (int e = 0; e < 15; e++) begin
            step();
            chk("t4r_busy", {31'd0, busy}, (e < 6) ? 32'd1 : 32'd0);
            chk("t4r_sel",  program_selector, 32'd0);
            chk("t4r_db",   {28'd0, btn_db}, (e < 5) ? 32'h9 : 32'h0);
        end

        // Reset during LOAD with button 1 held
        btn = 4'b0010;
        for (int e = 0; e < 7; e++) begin
            step();
            chk("t5_sel", program_selector, (e == 6) ? 32'd2 : 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("t5_async_sel",  program_selector, 32'd0);
        chk("t5_async_load", {31'd0, load_pulse}, 32'd0);
        chk("t5_async_busy", {31'd0, busy}, 32'd0);
        chk("t5_async_db",   {28'd0, btn_db}, 32'd0);
        step();
        chk("t5_hold_sel", program_selector, 32'd0);
        reset = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("t5b_sel",  program_selector, (e >= 6 && e <= 8) ? 32'd2 : 32'd0);
            chk("t5b_load", {31'd0, load_pulse}, (e == 6) ? 32'd1 : 32'd0);
            chk("t5b_db",   {28'd0, btn_db}, (e >= 5) ? 32'h2 : 32'h0);
        end
        btn = 4'b0000;
        for (int e = 0; e < 8; e++) step();
        chk("t5r_busy", {31'd0, busy}, 32'd0);

        // Display packing and pass-through
        sw = 16'h0306;
        #1;
        chk("t6_reg_before", disp_data, 32'd0);
        step();
        chk("t6_pack", disp_data, 32'h0003_0006);
        sw = 16'h7FFF;
        step();
        chk("t6_pack_full", disp_data, 32'h007F_00FF);
        sw       = 16'h8000;
        reg_data = 32'hDEAD_BEEF;
        step();
        chk("t6_pass", disp_data, 32'hDEAD_BEEF);
        reg_data = 32'h1234_5678;
        step();
        chk("t6_pass2", disp_data, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/labkit_ctl.md
# labkit_ctl

Parametrised front-panel controller for the labkit processor top level. It debounces N push-buttons, turns a press into a held program-selector code for the register file's program copy, and gates further loads until every button is released. It also registers the seven-segment display word, choosing between processor register output and packed switch input. It replaces the ad-hoc one-cycle selector and display mux in the top level, and connects directly to `regfile`'s `program_selector` input.

## Interface
Parameters:
- `N_BTN`, 4: number of program buttons; button i selects program i+1.
- `DB_CYCLES`, 16: consecutive stable cycles required to accept a level change (≥1).
- `HOLD_CYCLES`, 4: cycles `program_selector` holds a nonzero code (≥1).
- `DATA_W`, 32: width of `reg_data` / `disp_data`.
- `SW_W`, 16: switch width, even, ≤ DATA_W/2+1.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `btn` in N_BTN: raw, asynchronous button levels.
- `sw` in SW_W: raw switch levels.
- `reg_data` in DATA_W: processor output register value.
- `btn_db` out N_BTN: debounced button levels.
- `program_selector` out 32: 0 = none, i+1 = program i.
- `load_pulse` out 1: one-cycle strobe on the first cycle of a new selector code.
- `busy` out 1: high in LOAD and WAIT_RELEASE.
- `disp_data` out DATA_W: registered display word.

## Operation
- Reset values: `btn_db`=0, `program_selector`=0, `load_pulse`=0, `busy`=0, `disp_data`=0, FSM=IDLE, and all sync flops and counters = 0.
- Per-button debouncer: 2-flop synchroniser, then a counter. Counter increments while the synchronised level ≠ `btn_db[i]` and clears to 0 when equal. When the counter reaches DB_CYCLES, `btn_db[i]` toggles and the counter clears. Release uses the same rule as press.
- `press[i]` is an internal one-cycle pulse when `btn_db[i]` goes 0→1.
- FSM:
  - IDLE: if any `press` bit is set, the lowest index i wins. Then `program_selector`←i+1, `load_pulse`←1, hold counter←HOLD_CYCLES−1, go to LOAD.
  - LOAD: `load_pulse`←0, selector unchanged. If hold counter = 0, `program_selector`←0 and go to WAIT_RELEASE; else decrement.
  - WAIT_RELEASE: when `btn_db` = 0, go to IDLE.
  - Presses arriving outside IDLE are discarded, not queued.
- `busy` = (state ≠ IDLE), registered alongside the state.
- Display, with H = SW_W/2 and M = DATA_W/2:
  - If `sw[SW_W−1]`=1, `disp_data`←`reg_data`.
  - Else `disp_data`←0 with bits [H−1:0]=`sw[H−1:0]` and bits [M+H−2:M]=`sw[SW_W−2:H]`.
  - `sw` is used unsynchronised; display only.

## Timing
- Press latency: raw `btn[i]` rises and stays high before edge 0. `btn_db[i]` is high after edge 1+DB_CYCLES. `program_selector`, `load_pulse` and `busy` are valid after edge 2+DB_CYCLES.
- Selector is nonzero for exactly HOLD_CYCLES cycles, then returns to 0 for at least one cycle before any new code.
- Glitches shorter than DB_CYCLES cycles (after synchronisation) never change `btn_db`.
- Simultaneous presses in the same cycle: the lowest index wins and the others are dropped.
- A button held across HOLD expiry keeps the FSM in WAIT_RELEASE; no retrigger.
- `reset` mid-LOAD: outputs go to 0 asynchronously. After deassertion, a still-held button must re-debounce (counter from 0) before it can trigger.
- `disp_data` is valid one edge after `sw` or `reg_data` changes.

## Test plan
Parameters for all cases: DB_CYCLES=4, HOLD_CYCLES=3, N_BTN=4, DATA_W=32, SW_W=16.
- Reset then `btn`=4'b0001 held for 20 cycles: `program_selector`=1 for exactly 3 cycles starting edge 6; `load_pulse` high 1 cycle; `busy` high until release is debounced.
- 3-cycle glitch on `btn[2]`: `btn_db`, `program_selector` and `busy` stay 0 throughout.
- `btn`=4'b1010 rising in the same cycle: `program_selector`=2 (index 1 wins); no later code 4.
- Press `btn[0]`, then press `btn[3]` during LOAD, then release both: only code 1 appears; FSM returns to IDLE after both releases are debounced; no code 4.
- Assert `reset` during LOAD while `btn[1]` is still held: selector drops to 0 immediately. After deassertion, code 2 reappears 2+DB_CYCLES edges later.
- `sw`=16'h0306: `disp_data`=32'h0003_0006. Then `sw`=16'h8000 with `reg_data`=32'hDEAD_BEEF: `disp_data`=32'hDEAD_BEEF one edge later.
